// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc -- pipeline hazard controller for the 5-stage RV32 core.
//
// Provides MEM/WB operand forwarding, load-use stall, branch flush, a data
// memory wait-state freeze and a multi-cycle MUL/DIV occupancy FSM. It sits
// beside the datapath and drives the stall/flush enables of the pipeline
// registers.
//
// Optional feature: define HAZARD_PERF_EN to add four saturating
// performance counters (PerfLwStall, PerfMemWait, PerfMduWait, PerfFlush).
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   Rs1D/Rs2D, UsesRs1D/2D Decode source registers and their read flags
//   Rs1E/Rs2E, RdE        Execute source/destination registers
//   ResultSrcE            2'b01 marks a load in Execute
//   PCSrcE                taken branch/jump resolved in Execute
//   MduStartE             MDU op present in Execute (level)
//   RdM/RegWriteM         Memory-stage destination and write enable
//   MemReqM/MemReadyM     data-memory request and ready
//   RdW/RegWriteW         Writeback-stage destination and write enable
//   StallF/D/E/M          hold the respective pipeline register
//   FlushD/E/M/W          insert a bubble into the respective register
//   ForwardAE/BE          00 = register file, 01 = WB, 10 = MEM
//   MduBusy               MDU FSM is in BUSY
//   MduDoneE              one-cycle pulse: MDU result valid, E released
module hazard_unit_mc #(
  parameter int REG_AW  = 5,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic              UsesRs1D,
  input  logic              UsesRs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [1:0]        ResultSrcE,
  input  logic              PCSrcE,
  input  logic              MduStartE,
  input  logic [REG_AW-1:0] RdM,
  input  logic              RegWriteM,
  input  logic              MemReqM,
  input  logic              MemReadyM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteW,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              FlushW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              MduBusy,
`ifdef HAZARD_PERF_EN
  output logic [CNT_W-1:0]  PerfLwStall,
  output logic [CNT_W-1:0]  PerfMemWait,
  output logic [CNT_W-1:0]  PerfMduWait,
  output logic [CNT_W-1:0]  PerfFlush,
`endif
  output logic              MduDoneE
);

  localparam int CW = $clog2(MDU_LAT);
  localparam logic [CW-1:0] CNT_INIT = CW'(MDU_LAT - 2);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;

  logic memstall;
  logic mdustall;
  logic lwstall;

  // Forwarding: MEM has the younger value, so it wins over WB.
  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && Rs1E == RdM && Rs1E != '0)      ForwardAE = 2'b10;
    else if (RegWriteW && Rs1E == RdW && Rs1E != '0) ForwardAE = 2'b01;
    ForwardBE = 2'b00;
    if (RegWriteM && Rs2E == RdM && Rs2E != '0)      ForwardBE = 2'b10;
    else if (RegWriteW && Rs2E == RdW && Rs2E != '0) ForwardBE = 2'b01;
  end

  always_comb begin
    memstall = MemReqM & ~MemReadyM;
    lwstall  = (ResultSrcE == 2'b01) && (RdE != '0) &&
               ((UsesRs1D && Rs1D == RdE) || (UsesRs2D && Rs2D == RdE));
    // The first Execute cycle of an MDU op stalls from IDLE; the remaining
    // stall cycles come from BUSY while the counter is non-zero.
    mdustall = (state_reg == IDLE) ? (MduStartE & ~memstall)
                                   : (cnt_reg != '0);
    MduDoneE = (state_reg == BUSY) && (cnt_reg == '0) && !memstall;
    MduBusy  = (state_reg == BUSY);
  end

  // MDU occupancy FSM. The counter keeps running during memory waits so the
  // MDU latency is wall-clock; only the final release waits for memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (MduStartE && !memstall) begin
            state_reg <= BUSY;
            cnt_reg   <= CNT_INIT;
          end
        end
        BUSY: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
          end else if (!memstall) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Stall/flush priority: memory wait freezes everything, then MDU, then
  // load-use / branch. PCSrcE and lwstall stay valid across a freeze because
  // Execute is held.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    FlushW = 1'b0;
    if (memstall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (mdustall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else begin
      // A taken branch kills the dependent Decode instruction, so no stall.
      StallF = lwstall & ~PCSrcE;
      StallD = lwstall & ~PCSrcE;
      FlushD = PCSrcE;
      FlushE = lwstall | PCSrcE;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] perf_lw_reg;
  logic [CNT_W-1:0] perf_mem_reg;
  logic [CNT_W-1:0] perf_mdu_reg;
  logic [CNT_W-1:0] perf_flush_reg;

  logic lw_evt;
  logic mdu_evt;

  always_comb begin
    lw_evt  = !memstall && !mdustall && StallF;
    mdu_evt = !memstall && mdustall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_lw_reg    <= '0;
      perf_mem_reg   <= '0;
      perf_mdu_reg   <= '0;
      perf_flush_reg <= '0;
    end else begin
      if (lw_evt   && perf_lw_reg    != '1) perf_lw_reg    <= perf_lw_reg + 1'b1;
      if (memstall && perf_mem_reg   != '1) perf_mem_reg   <= perf_mem_reg + 1'b1;
      if (mdu_evt  && perf_mdu_reg   != '1) perf_mdu_reg   <= perf_mdu_reg + 1'b1;
      if (FlushD   && perf_flush_reg != '1) perf_flush_reg <= perf_flush_reg + 1'b1;
    end
  end

  assign PerfLwStall = perf_lw_reg;
  assign PerfMemWait = perf_mem_reg;
  assign PerfMduWait = perf_mdu_reg;
  assign PerfFlush   = perf_flush_reg;
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Self-checking bench for hazard_unit_mc: directed steps followed by random
// cycles, compared against a cycle-level reference model that tracks MDU
// progress as "cycles since the op was accepted".
module tb_hazard_unit_mc;
  localparam int REG_AW  = 5;
  localparam int MDU_LAT = 4;
  localparam int CNT_W   = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [REG_AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic UsesRs1D, UsesRs2D, PCSrcE, MduStartE, RegWriteM, MemReqM, MemReadyM, RegWriteW;
  logic [1:0] ResultSrcE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic MduBusy, MduDoneE;
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] PerfLwStall, PerfMemWait, PerfMduWait, PerfFlush;
`endif

  int compared = 0;
  int mismatched = 0;

  // reference model state
  int age = 0;   // 0 = no MDU op, else Execute cycles since the op was accepted
  longint m_lw = 0, m_mem = 0, m_mdu = 0, m_flush = 0;

  // expected outputs
  logic e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fm, e_fw, e_busy, e_done;
  logic [1:0] e_fa, e_fb;
  logic e_p1, e_p2, e_p3lw;

  int stall_e_cnt, done_cnt, busy_cnt;

  hazard_unit_mc #(.REG_AW(REG_AW), .MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .UsesRs1D(UsesRs1D), .UsesRs2D(UsesRs2D),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ResultSrcE(ResultSrcE),
    .PCSrcE(PCSrcE), .MduStartE(MduStartE),
    .RdM(RdM), .RegWriteM(RegWriteM), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .RdW(RdW), .RegWriteW(RegWriteW),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MduBusy(MduBusy),
`ifdef HAZARD_PERF_EN
    .PerfLwStall(PerfLwStall), .PerfMemWait(PerfMemWait),
    .PerfMduWait(PerfMduWait), .PerfFlush(PerfFlush),
`endif
    .MduDoneE(MduDoneE)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd(input logic [REG_AW-1:0] rs);
    if (rs == 0) return 2'b00;
    if (RegWriteM && rs == RdM) return 2'b10;
    if (RegWriteW && rs == RdW) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_eval();
    logic ms, lw, mdu;
    ms  = MemReqM && !MemReadyM;
    lw  = ResultSrcE == 2'b01 && RdE != 0 &&
          ((UsesRs1D && Rs1D == RdE) || (UsesRs2D && Rs2D == RdE));
    // MDU_LAT-1 stall cycles: the accept cycle plus ages 1..MDU_LAT-2
    mdu = (age == 0) ? (MduStartE && !ms) : (age <= MDU_LAT - 2);
    e_busy = (age != 0);
    e_done = (age >= MDU_LAT - 1) && !ms;
    e_fa = fwd(Rs1E);
    e_fb = fwd(Rs2E);
    {e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fm, e_fw} = '0;
    e_p1 = ms; e_p2 = !ms && mdu; e_p3lw = 1'b0;
    if (ms) begin
      {e_sf, e_sd, e_se, e_sm, e_fw} = '1;
    end else if (mdu) begin
      {e_sf, e_sd, e_se, e_fm} = '1;
    end else begin
      e_sf = lw && !PCSrcE;
      e_sd = e_sf;
      e_fd = PCSrcE;
      e_fe = lw || PCSrcE;
      e_p3lw = e_sf;
    end
  endtask

  task automatic check_all();
    model_eval();
    chk("StallF", StallF, e_sf);  chk("StallD", StallD, e_sd);
    chk("StallE", StallE, e_se);  chk("StallM", StallM, e_sm);
    chk("FlushD", FlushD, e_fd);  chk("FlushE", FlushE, e_fe);
    chk("FlushM", FlushM, e_fm);  chk("FlushW", FlushW, e_fw);
    chk("ForwardAE", ForwardAE, e_fa); chk("ForwardBE", ForwardBE, e_fb);
    chk("MduBusy", MduBusy, e_busy);   chk("MduDoneE", MduDoneE, e_done);
`ifdef HAZARD_PERF_EN
    chk("PerfLwStall", PerfLwStall, m_lw);  chk("PerfMemWait", PerfMemWait, m_mem);
    chk("PerfMduWait", PerfMduWait, m_mdu); chk("PerfFlush", PerfFlush, m_flush);
`endif
  endtask

  // One clock cycle with the currently driven inputs: check, clock, update model.
  task automatic step();
    logic ms;
    #3;
    check_all();
    if (StallE) stall_e_cnt++;
    if (MduDoneE) done_cnt++;
    if (MduBusy) busy_cnt++;
    ms = MemReqM && !MemReadyM;
    @(posedge clk);
    if (rst_n) begin
      if (e_p3lw) m_lw++;
      if (e_p1) m_mem++;
      if (e_p2) m_mdu++;
      if (e_fd) m_flush++;
      if (age == 0) begin
        if (MduStartE && !ms) age = 1;
      end else if (age >= MDU_LAT - 1) begin
        if (!ms) age = 0;
      end else begin
        age++;
      end
    end
    #1;
    $display("cycle t=%0t Sf=%b Sd=%b Se=%b Sm=%b Fd=%b Fe=%b Fm=%b Fw=%b FA=%b FB=%b busy=%b done=%b",
             $time, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
             ForwardAE, ForwardBE, MduBusy, MduDoneE);
  endtask

  task automatic idle_inputs();
    Rs1D = 0; Rs2D = 0; UsesRs1D = 0; UsesRs2D = 0;
    Rs1E = 0; Rs2E = 0; RdE = 0; ResultSrcE = 2'b00; PCSrcE = 0; MduStartE = 0;
    RdM = 0; RegWriteM = 0; MemReqM = 0; MemReadyM = 1; RdW = 0; RegWriteW = 0;
  endtask

  initial begin
    idle_inputs();
    // reset state
    #2;
    check_all();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1. forwarding priority and x0
    Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
    #3; chk("fwd_mem_wins", ForwardAE, 2'b10);
    step();
    Rs1E = 0;
    #3; chk("fwd_x0", ForwardAE, 2'b00);
    step();
    Rs2E = 5; RegWriteM = 0;
    step();
    idle_inputs();

    // 2. load-use stall
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; UsesRs2D = 1;
    #3; chk("lw_stallF", StallF, 1'b1); chk("lw_flushE", FlushE, 1'b1);
    step();
    UsesRs2D = 0;
    #3; chk("lw_nouse", StallF, 1'b0);
    step();

    // 3. load-use with taken branch
    UsesRs2D = 1; PCSrcE = 1;
    #3; chk("lwbr_stallF", StallF, 1'b0); chk("lwbr_flushD", FlushD, 1'b1);
    step();
    idle_inputs();

    // 4. MDU occupancy with start held
    stall_e_cnt = 0; done_cnt = 0; busy_cnt = 0;
    MduStartE = 1;
    for (int i = 0; i < MDU_LAT; i++) step();
    MduStartE = 0;
    chk("mdu_stall_cycles", stall_e_cnt, MDU_LAT - 1);
    chk("mdu_done_pulses", done_cnt, 1);
    chk("mdu_busy_cycles", busy_cnt, MDU_LAT - 1);
    step();
`ifdef HAZARD_PERF_EN
    chk("perf_mdu_after_t4", PerfMduWait, MDU_LAT - 1);
`endif

    // 5. memory wait with pending branch
    MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
    for (int i = 0; i < 3; i++) begin
      #3; chk("memw_flushD", FlushD, 1'b0); chk("memw_stallM", StallM, 1'b1);
      step();
    end
    MemReadyM = 1;
    #3; chk("memr_flushD", FlushD, 1'b1); chk("memr_flushE", FlushE, 1'b1);
    step();
    idle_inputs();

    // 6. reset in BUSY aborts the op
    MduStartE = 1;
    step(); step();
    rst_n = 1'b0;
    #1;
    age = 0; m_lw = 0; m_mem = 0; m_mdu = 0; m_flush = 0;
    chk("rst_busy", MduBusy, 1'b0);
    chk("rst_done", MduDoneE, 1'b0);
    MduStartE = 0;
    step();
    rst_n = 1'b1;
    step();

    // random cycles
    for (int n = 0; n < 400; n++) begin
      Rs1D = REG_AW'($urandom_range(0, 7)); Rs2D = REG_AW'($urandom_range(0, 7));
      UsesRs1D = 1'($urandom); UsesRs2D = 1'($urandom);
      Rs1E = REG_AW'($urandom_range(0, 7)); Rs2E = REG_AW'($urandom_range(0, 7));
      RdE = REG_AW'($urandom_range(0, 7));
      ResultSrcE = 2'($urandom_range(0, 3));
      PCSrcE = ($urandom_range(0, 4) == 0);
      MduStartE = ($urandom_range(0, 4) == 0);
      RdM = REG_AW'($urandom_range(0, 7)); RegWriteM = 1'($urandom);
      RdW = REG_AW'($urandom_range(0, 7)); RegWriteW = 1'($urandom);
      MemReqM = 1'($urandom); MemReadyM = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
